sc_dmem_io: RTL and testbench
=============================

# sc_dmem_io

Memory-side responder for the single-cycle CPU's data port. It answers the CPU's address, write-data and write-enable outputs and returns read data combinationally in the same cycle, because the CPU cannot stall. It holds the data RAM and a small memory-mapped I/O region:
- output port register
- 8-bit transmit FIFO with consumer handshake
- optional cycle counter

## Interface
Parameters:
- ADDR_WIDTH, 7: word-address bits of the RAM (2^ADDR_WIDTH 32-bit words).
- FIFO_DEPTH, 8: TX FIFO entries; must be a power of two, at least 2.

Ports (clock, reset first):
- clock  in  1  single clock, rising edge.
- resetn  in  1  reset, asynchronous and active-low.
- addr  in  32  byte address from the CPU ALU result.
- datain  in  32  store data from the CPU register file.
- we  in  1  store enable from the CPU.
- dataout  out  32  load data to the CPU write-back path; combinational.
- out_port  out  32  output port register.
- fifo_data  out  8  head byte of the TX FIFO.
- fifo_valid  out  1  FIFO not empty.
- fifo_ready  in  1  consumer accepts the head byte this cycle.

## Operation
Decode:
- addr[31:28] == 4'hF selects I/O. Any other value selects RAM.
- addr[1:0] are ignored, so all accesses are word accesses.

RAM:
- Word index is addr[ADDR_WIDTH+1:2]. Higher address bits alias.
- Read is combinational.
- Write happens on the clock edge when we=1.
- RAM is not reset; contents are undefined until written.

I/O map on addr[7:0]. Unmapped offsets read 0 and ignore writes.
- 0x00 OUT: read/write; the write loads out_port.
- 0x04 TXDATA: a write pushes datain[7:0]; reads return 0.
- 0x08 STATUS, read-only:
  - bits [15:8] = count
  - bit 2 = overflow (sticky)
  - bit 1 = full
  - bit 0 = empty
  - remaining bits 0
- 0x0C CLR: a write of any value clears overflow.
- 0x10 CYCLE: read returns the counter; a write loads datain. Present only with the macro.

FIFO behaviour:
- Pop: fifo_valid && fifo_ready at the edge.
- Push: a TXDATA write.
- Push while full with no simultaneous pop: the byte is dropped and overflow is set.
- Push while full with a simultaneous pop: the push is accepted and count stays at FIFO_DEPTH.
- Push and pop on the same edge while not full: both happen and count is unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- fifo_data is the stored head entry and is don't-care when fifo_valid=0.

Cycle counter:
- Increments by 1 every cycle and wraps from 0xFFFFFFFF to 0.
- If a CYCLE write and an increment fall on the same edge, the written value wins.

## Timing
- dataout is valid in the same cycle as addr; there is no pipelining and no wait states.
- Every write takes effect at the rising edge where we=1. A load from the same address in the next cycle returns the new value.
- A pushed byte is visible on fifo_valid/fifo_data after that push's edge. A STATUS read in the next cycle reflects the new count.
- The next FIFO entry appears on fifo_data the cycle after a pop.
- Reset values:
  - out_port = 0
  - FIFO empty, fifo_valid = 0, count = 0
  - overflow = 0
  - cycle counter = 0
  - dataout follows the decode combinationally; a STATUS read during reset returns 0x00000001.
- resetn asserted mid-operation immediately discards FIFO contents and clears all registers. RAM is unaffected.
- The first edge after resetn deasserts is a normal cycle; the counter reads 1 after it.

## Configuration
- SC_DMEM_CYCLE_COUNTER_EN defined: the 32-bit cycle counter exists at 0x10 as specified.
- SC_DMEM_CYCLE_COUNTER_EN undefined: no counter flops are present. 0x10 behaves as unmapped (reads 0, writes ignored).

## Structure
- Package sc_dmem_pkg holds:
  - IO_REGION nibble (4'hF)
  - offset constants OUT, TXDATA, STATUS, CLR, CYCLE
  - STATUS bit positions
- One sub-module, sc_byte_fifo: parameterised depth, push/pop/full/empty/count, with the same-edge push/pop rules above. sc_dmem_io instantiates it once.

## Test plan
- Store 0xDEADBEEF to 0x00000010, then load 0x00000010 → 0xDEADBEEF. Load 0x00000013 → the same word. Load 0x00000010 + 2^(ADDR_WIDTH+2) → the same word (alias).
- Write 0x000000A5 to 0xF0000000 → out_port = 0x000000A5 after the edge; a read of 0xF0000000 returns it. Assert resetn=0 mid-cycle → out_port = 0 immediately.
- Hold fifo_ready=0 and push bytes 0x01..0x09 → STATUS = 0x00000806 (count 8, overflow, full). Then fifo_ready=1 → bytes 0x01..0x08 are popped in order; 0x09 is lost.
- With the FIFO full, push 0x55 while popping on the same edge → count stays 8 and 0x55 is the last byte out. Write CLR → overflow = 0.
- With the macro defined, write 0xFFFFFFFE to 0xF0000010 → reads 0xFFFFFFFE in the next cycle, then 0xFFFFFFFF, then 0x00000000.
- With the macro undefined, reading 0xF0000010 → 0 and writes have no effect.

Source files
------------

// File: rtl/sc_dmem_pkg.sv
// sc_dmem_pkg: I/O decode constants and STATUS layout shared by the data-memory responder.
package sc_dmem_pkg;
   localparam logic [3:0] IO_REGION  = 4'hF;
   localparam logic [7:0] OFF_OUT    = 8'h00;
   localparam logic [7:0] OFF_TXDATA = 8'h04;
   localparam logic [7:0] OFF_STATUS = 8'h08;
   localparam logic [7:0] OFF_CLR    = 8'h0C;
   localparam logic [7:0] OFF_CYCLE  = 8'h10;
   localparam int ST_EMPTY    = 0;
   localparam int ST_FULL     = 1;
   localparam int ST_OVERFLOW = 2;
   localparam int ST_COUNT    = 8;

   function automatic logic [31:0] status_word(logic [7:0] cnt, logic ovf, logic full, logic empty);
      status_word = '0;
      status_word[ST_COUNT +: 8] = cnt;
      status_word[ST_OVERFLOW] = ovf;
      status_word[ST_FULL] = full;
      status_word[ST_EMPTY] = empty;
   endfunction
endpackage

// File: rtl/sc_byte_fifo.sv
// sc_byte_fifo: power-of-two byte FIFO; a push into a full FIFO is accepted only alongside a pop.
module sc_byte_fifo #(
   parameter int DEPTH = 8,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = PW + 1
) (
   input  logic          clock,
   input  logic          resetn,
   input  logic          push,
   input  logic          pop,
   input  logic [7:0]    wdata,
   output logic [7:0]    rdata,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);
   logic [7:0] mem [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic do_push, do_pop;

   assign do_pop = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign full = count == CW'(DEPTH);
   assign empty = count == '0;
   assign rdata = mem[rd_ptr];

   // When full, wr_ptr equals rd_ptr: a push with pop overwrites the departing head slot.
   always_ff @(posedge clock)
      if (do_push) mem[wr_ptr] <= wdata;

   always_ff @(posedge clock or negedge resetn)
      if (!resetn) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop) rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
endmodule

// File: rtl/sc_dmem_io.sv
// sc_dmem_io: single-cycle CPU data-port responder with RAM, output port, TX FIFO and optional cycle counter.
// Define SC_DMEM_CYCLE_COUNTER_EN to add the 32-bit cycle counter at I/O offset 0x10.
module sc_dmem_io
   import sc_dmem_pkg::*;
#(
   parameter int ADDR_WIDTH = 7,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic [31:0] addr,
   input  logic [31:0] datain,
   input  logic        we,
   output logic [31:0] dataout,
   output logic [31:0] out_port,
   output logic [7:0]  fifo_data,
   output logic        fifo_valid,
   input  logic        fifo_ready
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   logic [31:0] ram [2**ADDR_WIDTH];
   logic [ADDR_WIDTH-1:0] idx;
   logic [7:0] off;
   logic [CW-1:0] count;
   logic [31:0] cycle_rd, io_rd;
   logic io, io_we, push, pop, full, empty, overflow;
   logic unused_addr;

   assign io = addr[31:28] == IO_REGION;
   assign off = {addr[7:2], 2'b00};
   assign idx = addr[ADDR_WIDTH+1:2];
   assign io_we = we && io;
   assign push = io_we && off == OFF_TXDATA;
   assign pop = fifo_valid && fifo_ready;
   assign fifo_valid = !empty;
   assign unused_addr = ^{addr[27:8], addr[1:0]};

   always_ff @(posedge clock)
      if (we && !io) ram[idx] <= datain;

   always_ff @(posedge clock or negedge resetn)
      if (!resetn) begin
         out_port <= '0;
         overflow <= 1'b0;
      end else begin
         if (io_we && off == OFF_OUT) out_port <= datain;
         if (io_we && off == OFF_CLR) overflow <= 1'b0;
         else if (push && full && !pop) overflow <= 1'b1;
      end

`ifdef SC_DMEM_CYCLE_COUNTER_EN
   logic [31:0] cycle;
   always_ff @(posedge clock or negedge resetn)
      if (!resetn) cycle <= '0;
      else cycle <= (io_we && off == OFF_CYCLE) ? datain : cycle + 32'd1;
   assign cycle_rd = cycle;
`else
   assign cycle_rd = '0;
`endif

   assign io_rd = (off == OFF_OUT)    ? out_port :
                  (off == OFF_STATUS) ? status_word(8'(count), overflow, full, empty) :
                  (off == OFF_CYCLE)  ? cycle_rd : 32'd0;
   assign dataout = io ? io_rd : ram[idx];

   sc_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clock(clock),
      .resetn(resetn),
      .push(push),
      .pop(pop),
      .wdata(datain[7:0]),
      .rdata(fifo_data),
      .full(full),
      .empty(empty),
      .count(count)
   );
endmodule

// File: tb/tb_sc_dmem_io.sv
// tb_sc_dmem_io: randomized and directed checks of sc_dmem_io against a queue/array reference model.
module tb_sc_dmem_io;
   localparam int AW = 7;
   localparam int DEPTH = 8;
   localparam int WORDS = 2**AW;

   logic clock = 0, resetn = 0, we = 0, fifo_ready = 0;
   logic [31:0] addr = 0, datain = 0;
   logic [31:0] dataout, out_port;
   logic [7:0] fifo_data;
   logic fifo_valid;
   int n_cmp = 0, n_err = 0;

   logic [31:0] ram_m [WORDS];
   bit ram_v [WORDS];
   logic [31:0] out_m, cyc_m;
   bit ovf_m;
   logic [7:0] q [$];

   always #5 clock = ~clock;

   sc_dmem_io #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
      .clock(clock), .resetn(resetn), .addr(addr), .datain(datain), .we(we),
      .dataout(dataout), .out_port(out_port), .fifo_data(fifo_data),
      .fifo_valid(fifo_valid), .fifo_ready(fifo_ready)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit model_read(input logic [31:0] a, output logic [31:0] v);
      int w;
      w = int'((a >> 2) % WORDS);
      v = 0;
      if (a[31:28] != 4'hF) begin
         v = ram_m[w];
         return ram_v[w];
      end
      case (a[7:0] & 8'hFC)
         8'h00: v = out_m;
         8'h08: v = {16'd0, 8'(q.size()), 5'd0, ovf_m, q.size() == DEPTH, q.size() == 0};
`ifdef SC_DMEM_CYCLE_COUNTER_EN
         8'h10: v = cyc_m;
`endif
         default: v = 0;
      endcase
      return 1;
   endfunction

   task automatic model_reset();
      out_m = 0;
      ovf_m = 0;
      cyc_m = 0;
      q.delete();
   endtask

   // One bus cycle: drive, check combinational outputs mid-cycle, then advance the model at the edge.
   task automatic cyc(input logic [31:0] a, input logic [31:0] d, input bit w, input bit r);
      logic [31:0] v;
      logic [7:0] o;
      bit io, pop, was_full;
      int wi;
      addr = a; datain = d; we = w; fifo_ready = r;
      @(negedge clock);
      if (model_read(a, v)) check("dataout", dataout, v);
      check("out_port", out_port, out_m);
      check("fifo_valid", 32'(fifo_valid), 32'(q.size() != 0));
      if (q.size() != 0) check("fifo_data", 32'(fifo_data), 32'(q[0]));
      @(posedge clock);
      io = a[31:28] == 4'hF;
      o = a[7:0] & 8'hFC;
      wi = int'((a >> 2) % WORDS);
      pop = r && q.size() != 0;
      was_full = q.size() == DEPTH;
      if (pop) void'(q.pop_front());
      if (w && io && o == 8'h04) begin
         if (was_full && !pop) ovf_m = 1;
         else q.push_back(d[7:0]);
      end
      if (w && io && o == 8'h00) out_m = d;
      if (w && io && o == 8'h0C) ovf_m = 0;
      if (w && !io) begin
         ram_m[wi] = d;
         ram_v[wi] = 1;
      end
`ifdef SC_DMEM_CYCLE_COUNTER_EN
      cyc_m = (w && io && o == 8'h10) ? d : cyc_m + 1;
`endif
      #1;
   endtask

   task automatic pulse_reset();
      addr = 32'hF000_0008; we = 0;
      resetn = 0;
      #1;
      check("rst_out_port", out_port, 0);
      check("rst_fifo_valid", 32'(fifo_valid), 0);
      check("rst_status", dataout, 32'h1);
      model_reset();
      #1 resetn = 1;
   endtask

   initial begin
      logic [31:0] a;
      model_reset();
      addr = 32'hF000_0008;
      #2;
      check("reset_status", dataout, 32'h1);
      check("reset_out_port", out_port, 0);
      check("reset_fifo_valid", 32'(fifo_valid), 0);
      @(posedge clock); #1 resetn = 1;
      cyc(32'hF000_0010, 0, 0, 0);
      cyc(32'hF000_0010, 0, 0, 0);

      cyc(32'h0000_0010, 32'hDEAD_BEEF, 1, 0);
      cyc(32'h0000_0010, 0, 0, 0);
      check("ram_read", dataout, 32'hDEAD_BEEF);
      cyc(32'h0000_0013, 0, 0, 0);
      check("ram_low_bits", dataout, 32'hDEAD_BEEF);
      cyc(32'h0000_0010 + (32'h1 << (AW + 2)), 0, 0, 0);
      check("ram_alias", dataout, 32'hDEAD_BEEF);

      cyc(32'hF000_0000, 32'h0000_00A5, 1, 0);
      check("out_port_write", out_port, 32'hA5);
      cyc(32'hF000_0000, 0, 0, 0);
      cyc(32'hF000_0004, 32'h77, 1, 0);
      pulse_reset();

      for (int i = 1; i <= 9; i++) cyc(32'hF000_0004, i, 1, 0);
      cyc(32'hF000_0008, 0, 0, 0);
      check("status_overflow", dataout, 32'h0000_0806);
      for (int i = 0; i < 9; i++) cyc(32'hF000_0000, 0, 0, 1);
      check("drained", 32'(fifo_valid), 0);

      for (int i = 0; i < 8; i++) cyc(32'hF000_0004, 32'h10 + i, 1, 0);
      cyc(32'hF000_0004, 32'h55, 1, 1);
      cyc(32'hF000_0008, 0, 0, 0);
      check("full_push_pop", dataout, 32'h0000_0806);
      for (int i = 0; i < 7; i++) cyc(32'hF000_0000, 0, 0, 1);
      check("last_byte", 32'(fifo_data), 32'h55);
      cyc(32'hF000_0000, 0, 0, 1);
      cyc(32'hF000_000C, 32'h1234, 1, 0);
      cyc(32'hF000_0008, 0, 0, 0);
      check("overflow_cleared", dataout, 32'h1);

      cyc(32'hF000_0010, 32'hFFFF_FFFE, 1, 0);
      cyc(32'hF000_0010, 0, 0, 0);
      cyc(32'hF000_0010, 0, 0, 0);
      cyc(32'hF000_0010, 0, 0, 0);
`ifdef SC_DMEM_CYCLE_COUNTER_EN
      check("cycle_wrap", dataout, 32'h0000_0001);
`else
      check("cycle_absent", dataout, 32'h0);
`endif

      repeat (3000) begin
         if ($urandom_range(0, 3) < 2) begin
            a = $urandom;
            if (a[31:28] == 4'hF) a[31:28] = 4'h0;
         end else begin
            a = {4'hF, 20'($urandom), 8'($urandom_range(0, 6) * 4 + $urandom_range(0, 3))};
         end
         if ($urandom_range(0, 499) == 0) pulse_reset();
         cyc(a, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
